// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the buffered UART transmitter.
// The producer drives tx_data/tx_valid; the transmitter answers with tx_ready.
`timescale 1ns/1ps
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter.
// Bytes enter a DEPTH-entry FIFO over a valid/ready handshake and are sent
// LSB first. Frames are sent back to back whenever the FIFO holds data.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_tx_if.slave               s_bus,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift, shift_next;
    logic             tx_next;

    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push, pop, baud_last, fifo_nempty;

    assign s_bus.tx_ready = (count != CW'(DEPTH));
    assign push           = s_bus.tx_valid && s_bus.tx_ready;
    assign fifo_nempty    = (count != '0);
    assign baud_last      = (baud_cnt == CNT_W'(DIV - 1));
    assign busy           = (state != IDLE) || fifo_nempty;

    // Next-state, pop decision and next line level for the frame sequencer.
    // A pop uses the registered count, so a byte pushed into an empty FIFO
    // is only popped on the following edge.
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        pop           = 1'b0;
        tx_next       = 1'b1;

        case (state)
            IDLE: begin
                baud_cnt_next = '0;
                if (fifo_nempty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    state_next = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = 3'd0;
                    state_next    = DATA;
                end else begin
                    baud_cnt_next = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shift_next   = shift >> 1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    // Chain straight into the next start bit when data waits.
                    if (fifo_nempty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_cnt_next = baud_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                baud_cnt_next = '0;
            end
        endcase

        // The line level is registered, so derive it from where we go next.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    // Control state: sequencer, baud counter, line register and FIFO bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            tx       <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            tx       <= tx_next;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Data storage: FIFO array and shift register carry no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_bus.tx_data;
        shift <= shift_next;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with DIV=10 and DEPTH=4.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DEPTH    = 4;
    localparam int DIV      = 10;

    logic       clk;
    logic       rst;
    logic       tx;
    logic       busy;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;
    int sizes [4] = '{4, 4, 4, 1};

    uart_tx_if bus ();

    uart_tx_fifo #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .s_bus (bus),
        .tx    (tx),
        .busy  (busy),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        step();
        bus.tx_valid = 1'b0;
    endtask

    function automatic logic fbit(input logic [7:0] b, input int k);
        int idx;
        idx = k / DIV;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    // Check tx (and busy) for frame cycles k0..k1-1, stepping one clock each.
    task automatic expect_frame(input logic [7:0] b, input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            chk($sformatf("frame_%02h_k%0d", b, k), 32'(tx), 32'(fbit(b, k)));
            chk($sformatf("busy_%02h_k%0d", b, k), 32'(busy), 32'd1);
            step();
        end
    endtask

    initial begin
        int v;
        int n;
        int k0;

        rst          = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        #2;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(bus.tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Single byte 0x61
        push(8'h61);
        chk("single_count1", 32'(count), 32'd1);
        chk("single_busy_rise", 32'(busy), 32'd1);
        chk("single_tx_idle", 32'(tx), 32'd1);
        step();
        chk("single_count0", 32'(count), 32'd0);
        expect_frame(8'h61, 0, 100);
        chk("single_busy_fall", 32'(busy), 32'd0);
        chk("single_tx_end", 32'(tx), 32'd1);

        // Back-to-back 0x55, 0xA3, 0x00
        push(8'h55);
        chk("b2b_count_a", 32'(count), 32'd1);
        push(8'hA3);
        chk("b2b_count_b", 32'(count), 32'd1);
        chk("b2b_start", 32'(tx), 32'd0);
        push(8'h00);
        chk("b2b_count_c", 32'(count), 32'd2);
        expect_frame(8'h55, 1, 100);
        chk("b2b_count_d", 32'(count), 32'd1);
        expect_frame(8'hA3, 0, 100);
        chk("b2b_count_e", 32'(count), 32'd0);
        expect_frame(8'h00, 0, 100);
        chk("b2b_busy_fall", 32'(busy), 32'd0);
        chk("b2b_tx_end", 32'(tx), 32'd1);

        // Full FIFO with tx_valid held
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h10;
        step();
        chk("full_count1", 32'(count), 32'd1);
        bus.tx_data = 8'h11;
        step();
        bus.tx_data = 8'h12;
        step();
        bus.tx_data = 8'h13;
        step();
        bus.tx_data = 8'h14;
        step();
        chk("full_count4", 32'(count), 32'd4);
        chk("full_ready0", 32'(bus.tx_ready), 32'd0);
        bus.tx_data = 8'h15;
        expect_frame(8'h10, 3, 100);
        chk("full_count3", 32'(count), 32'd3);
        chk("full_ready1", 32'(bus.tx_ready), 32'd1);
        step();
        bus.tx_valid = 1'b0;
        chk("full_refill", 32'(count), 32'd4);
        chk("full_ready0b", 32'(bus.tx_ready), 32'd0);
        expect_frame(8'h11, 1, 100);
        expect_frame(8'h12, 0, 100);
        expect_frame(8'h13, 0, 100);
        expect_frame(8'h14, 0, 100);
        expect_frame(8'h15, 0, 100);
        chk("full_busy_fall", 32'(busy), 32'd0);
        chk("full_count_end", 32'(count), 32'd0);

        // Push on the exact cycle a STOP ends, count=2
        push(8'h5A);
        push(8'hC3);
        push(8'h81);
        chk("sim_count2", 32'(count), 32'd2);
        expect_frame(8'h5A, 1, 99);
        bus.tx_data  = 8'h7E;
        bus.tx_valid = 1'b1;
        expect_frame(8'h5A, 99, 100);
        bus.tx_valid = 1'b0;
        chk("sim_count_hold", 32'(count), 32'd2);
        expect_frame(8'hC3, 0, 100);
        expect_frame(8'h81, 0, 100);
        expect_frame(8'h7E, 0, 100);
        chk("sim_busy_fall", 32'(busy), 32'd0);

        // Reset during DATA bit 3 of 0xFF with two queued
        push(8'hFF);
        push(8'hFF);
        push(8'hFF);
        chk("rmid_count2", 32'(count), 32'd2);
        expect_frame(8'hFF, 1, 45);
        rst = 1'b1;
        #1;
        chk("rmid_tx", 32'(tx), 32'd1);
        chk("rmid_count", 32'(count), 32'd0);
        chk("rmid_busy", 32'(busy), 32'd0);
        chk("rmid_ready", 32'(bus.tx_ready), 32'd1);
        step();
        step();
        rst = 1'b0;
        step();
        chk("rmid_post_tx", 32'(tx), 32'd1);
        chk("rmid_post_busy", 32'(busy), 32'd0);
        push(8'h3C);
        chk("rmid_push_count", 32'(count), 32'd1);
        step();
        chk("rmid_pop_count", 32'(count), 32'd0);
        expect_frame(8'h3C, 0, 100);
        chk("rmid_busy_fall", 32'(busy), 32'd0);
        chk("rmid_tx_end", 32'(tx), 32'd1);

        // Pointer wrap: 3*DEPTH+1 incrementing bytes
        v = 8'h20;
        for (int r = 0; r < 4; r++) begin
            n = sizes[r];
            for (int i = 0; i < n; i++) push(8'(v + i));
            if (n == 1) begin
                step();
                k0 = 0;
            end else begin
                k0 = n - 2;
            end
            expect_frame(8'(v), k0, 100);
            for (int i = 1; i < n; i++) expect_frame(8'(v + i), 0, 100);
            chk($sformatf("wrap_busy_r%0d", r), 32'(busy), 32'd0);
            chk($sformatf("wrap_count_r%0d", r), 32'(count), 32'd0);
            v = v + n;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter for the Artix-7 UART design: accepts bytes over a valid/ready handshake into a FIFO and serialises them on `tx` as 8N1 frames, LSB first. It is the sending end of the serial link whose receiving end drives the seven-segment display. It replaces the single fixed-byte, button-triggered transmit path with queued, back-to-back transmission of arbitrary bytes.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate in bits/s.
- `DEPTH`, 16: FIFO depth in bytes; must be a power of two, ≥2.
- `clk` in 1: single system clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `tx_data` in 8: byte to queue.
- `tx_valid` in 1: `tx_data` is valid this cycle.
- `tx_ready` out 1: FIFO can accept a byte; equals (count != DEPTH).
- `tx` out 1: serial output, registered; idle high.
- `busy` out 1: high while a frame is on the line or the FIFO is non-empty.
- `count` out $clog2(DEPTH)+1: bytes currently held in the FIFO, excluding the byte being shifted.

## Operation
- Bit period: DIV = CLK_FREQ/BAUD, integer truncation. Each bit lasts exactly DIV clocks. The baud counter runs from 0 to DIV-1 and restarts at every bit boundary.
- Push: a byte is written when `tx_valid && tx_ready` at a rising edge. `tx_data` is captured at that edge. `tx_valid` while `tx_ready`=0 is ignored; the byte is dropped and FIFO state is unchanged.
- FIFO pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. `count` goes up by 1 on push only, down by 1 on pop only, and is unchanged on simultaneous push and pop.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If count>0, pop the head into the shift register and go to START.
  - START: `tx`=0 for DIV clocks, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for DIV clocks per bit, shifting right. After bit 7, go to STOP.
  - STOP: `tx`=1 for DIV clocks. At the end, if count>0, pop and go directly to START with no extra idle cycle. Otherwise go to IDLE.
- A pop and a push in the same cycle are both honoured. When count=0 a pushed byte cannot be popped in its push cycle; it is popped on the following edge.
- Full: count=DEPTH forces `tx_ready`=0. A pop in that cycle makes `tx_ready`=1 from the next cycle.
- `busy` = (state != IDLE) || (count != 0).

## Timing
- Reset values: `tx`=1, `tx_ready`=1, `busy`=0, `count`=0, state=IDLE, pointers=0, baud counter=0.
- Latency from push into an empty, idle block: byte accepted at edge N, count=1 after N; pop at edge N+1; `tx` low from edge N+1.
- `busy` rises after edge N (from count) and falls at the same edge `tx` returns to IDLE after the last stop bit.
- Frame length is exactly 10·DIV clocks. Back-to-back frames are contiguous: the next start bit begins the cycle after the stop bit's DIV-th clock.
- `tx_ready` is combinational from `count` and has no same-cycle dependence on `tx_valid`.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronously), the FIFO is emptied, and the in-flight byte is discarded. After release, the first push behaves exactly as from power-up.

## Test plan
- Single byte (CLK_FREQ=1_000_000, BAUD=100_000, DIV=10): push 0x61 → `tx` low 2 edges later for 10 clocks, then 1,0,0,0,0,1,1,0 each for 10 clocks, stop high for 10 clocks; `busy` high for exactly 101 cycles.
- Back-to-back: push 0x55, 0xA3, 0x00 on consecutive cycles → three contiguous 100-clock frames with no idle gap; `count` goes 1,1,2,1,0 over time; `busy` falls after 301 cycles.
- Full: with DEPTH=4, hold `tx_valid` with bytes 0x10..0x17 → bytes 0x10–0x14 accepted (1 popped plus 4 queued); `tx_ready`=0 while count=4; rejected bytes never appear; `tx_ready` rises for one push per completed frame; wire order is 0x10,0x11,0x12,0x13,0x14 plus later accepted bytes.
- Simultaneous push/pop: at count=2, push on the exact cycle a STOP ends → `count` stays 2; byte order on the wire is preserved.
- Reset mid-frame: assert `rst` during DATA bit 3 of 0xFF with 2 bytes queued → `tx`=1 and `count`=0 immediately; after release, push 0x3C → single clean 0x3C frame.
- Pointer wrap: push and drain 3·DEPTH+1 incrementing bytes → all received in order, no loss or duplication.
